cac_update_drain: RTL

- Receiving end of the two-lane CaC update interface.
- Accepts the per-lane (valid, DestVid, Update) outputs of the combine-and-compare stage and buffers each lane in its own FIFO.
- Serializes both lanes round-robin onto one valid/ready update stream feeding the vertex-apply logic.
- CaC has no ready input, so this block drives an early Stall back upstream and flags any overflow.

---
 rtl/cac_update_drain.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cac_update_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cac_update_drain                                           |
// | Description : Receiving end of the two-lane CaC update interface. Each   |
// |               lane is buffered in its own FIFO. The two FIFOs are        |
// |               serialized round-robin onto a single valid/ready stream.   |
// |               The upstream has no ready input, so an early registered    |
// |               Stall is driven back and dropped updates are flagged.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk                  clock                                             |
// |   rst                  synchronous reset, active-low                     |
// |   InputValid_A/_B      per-lane update valid (no ready upstream)         |
// |   InDestVid_A/_B       per-lane destination vertex id                    |
// |   InUpdate_A/_B        per-lane update value                             |
// |   Stall                registered backpressure to upstream               |
// |   OutValid/OutReady    serialized output handshake                       |
// |   OutDestVid/OutUpdate serialized output payload                         |
// |   OutLane              source lane of the presented update (0=A, 1=B)    |
// |   Overflow             sticky: an update was dropped since reset         |
// +--------------------------------------------------------------------------+
module cac_update_drain #(
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InputValid_A,
  input  logic              InputValid_B,
  input  logic [DATA_W-1:0] InDestVid_A,
  input  logic [DATA_W-1:0] InDestVid_B,
  input  logic [DATA_W-1:0] InUpdate_A,
  input  logic [DATA_W-1:0] InUpdate_B,
  output logic              Stall,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutDestVid,
  output logic [DATA_W-1:0] OutUpdate,
  output logic              OutLane,
  output logic              Overflow
);

  localparam int              c_AW   = $clog2(FIFO_DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam int              c_EW   = 2 * DATA_W;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_THR  = c_CW'(FIFO_DEPTH - PIPE_DEPTH);

  // Lane index 0 = A, 1 = B throughout.
  logic [1:0]      w_in_valid;
  logic [c_EW-1:0] w_in_data [2];
  logic [c_EW-1:0] w_head    [2];
  logic [1:0]      w_empty;
  logic [1:0]      w_full;
  logic [1:0]      w_pop;
  logic [1:0]      w_drop;
  logic [1:0]      w_hi;

  logic            w_load;
  logic            w_both;
  logic            w_grant;
  logic [c_EW-1:0] w_sel;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_dest;
  logic [DATA_W-1:0] r_out_upd;
  logic              r_out_lane;
  logic              r_rr;
  logic              r_stall;
  logic              r_ovf;

  assign w_in_valid   = {InputValid_B, InputValid_A};
  assign w_in_data[0] = {InDestVid_A, InUpdate_A};
  assign w_in_data[1] = {InDestVid_B, InUpdate_B};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wp;
    logic [c_AW-1:0] r_rp;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_push;

    assign w_full[l]  = (r_cnt == c_FULL);
    assign w_empty[l] = (r_cnt == '0);
    assign w_head[l]  = r_mem[r_rp];
    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign w_push     = w_in_valid[l] && (!w_full[l] || w_pop[l]);
    assign w_drop[l]  = w_in_valid[l] && w_full[l] && !w_pop[l];
    // Stall looks at the count as it will be after this edge.
    assign w_hi[l]    = (w_cnt_nxt >= c_THR);

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop[l]) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else if (!w_push && w_pop[l]) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wp] <= w_in_data[l];
      end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) begin
          r_wp <= r_wp + 1'b1;
        end
        if (w_pop[l]) begin
          r_rp <= r_rp + 1'b1;
        end
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  // Output register refills whenever it is empty or being consumed.
  assign w_load  = (!r_out_valid || OutReady) && (w_empty != 2'b11);
  assign w_both  = (w_empty == 2'b00);
  // 1 selects lane B; a lone non-empty lane wins regardless of the pointer.
  assign w_grant = w_both ? r_rr : w_empty[0];
  assign w_pop   = {w_load && w_grant, w_load && !w_grant};
  assign w_sel   = w_head[w_grant];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_dest  <= '0;
      r_out_upd   <= '0;
      r_out_lane  <= 1'b0;
      r_rr        <= 1'b0;
      r_stall     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_dest  <= w_sel[c_EW-1:DATA_W];
        r_out_upd   <= w_sel[DATA_W-1:0];
        r_out_lane  <= w_grant;
        // Only contested grants advance the round-robin pointer.
        if (w_both) begin
          r_rr <= ~r_rr;
        end
      end else if (OutReady) begin
        r_out_valid <= 1'b0;
      end
      r_stall <= |w_hi;
      if (|w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign Stall      = r_stall;
  assign OutValid   = r_out_valid;
  assign OutDestVid = r_out_dest;
  assign OutUpdate  = r_out_upd;
  assign OutLane    = r_out_lane;
  assign Overflow   = r_ovf;

endmodule
`default_nettype wire
